// File: rtl/biu_bus_arbiter.sv
// Two-requester memory bus arbiter (load/store over fetch, starvation guard, timeout); one transaction in flight.
// Latency: gnt one cycle after req, done one cycle after mem_ready; no backpressure on gnt/done pulses.
module biu_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state, state_nxt;
    logic          owner_ls;
    logic [CW-1:0] consec;
    logic [7:0]    timer;
    logic          timed_out;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          f_gnt_q;
    logic          ls_gnt_q;

    logic any_req;
    logic pick_ls;
    logic timer_hit;

    assign any_req   = f_req | ls_req;
    // Fetch only overrides a pending load/store once the guard has saturated.
    assign pick_ls   = ls_req && !(f_req && (consec == CW'(MAX_CONSEC)));
    assign timer_hit = (timer + 8'd1) == 8'(TIMEOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUS;
            BUS:     if (mem_ready || timer_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            consec    <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            f_gnt_q   <= 1'b0;
            ls_gnt_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            f_gnt_q  <= 1'b0;
            ls_gnt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_ls  <= pick_ls;
                        f_gnt_q   <= !pick_ls;
                        ls_gnt_q  <= pick_ls;
                        timer     <= '0;
                        timed_out <= 1'b0;
                        if (pick_ls) begin
                            addr_q  <= ls_addr;
                            we_q    <= ls_we;
                            wdata_q <= ls_wdata;
                            if (!f_req)
                                consec <= '0;
                            else if (consec != CW'(MAX_CONSEC))
                                consec <= consec + CW'(1);
                        end else begin
                            addr_q  <= f_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            consec  <= '0;
                        end
                    end
                end
                BUS: begin
                    // A late mem_ready still beats the timeout in the same cycle.
                    if (mem_ready) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                        timer   <= '0;
                    end else if (timer_hit) begin
                        rdata_q   <= '0;
                        timed_out <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    rdata_q   <= '0;
                    timed_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign f_gnt     = f_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign busy      = (state != IDLE);
    assign mem_req   = (state == BUS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign f_done    = (state == DONE) && !owner_ls;
    assign ls_done   = (state == DONE) && owner_ls;
    assign err       = (state == DONE) && timed_out;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Scoreboard bench for biu_bus_arbiter: directed stimulus pushes expected transactions, a monitor checks them.
module tb_biu_bus_arbiter;
    localparam int NEVER = 100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_gnt, f_done;
    logic [31:0] f_addr;
    logic        ls_req, ls_we, ls_gnt, ls_done;
    logic [31:0] ls_addr, ls_wdata;
    logic [31:0] rdata;
    logic        err, busy;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    biu_bus_arbiter #(.AW(32), .DW(32), .MAX_CONSEC(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done),
        .rdata(rdata), .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   done_cyc = 0;
    int   mon_cnt = 0;
    int   mem_wait = 0;
    int   bus_cnt = 0;
    int   t0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    task automatic push(input bit is_ls, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit e, input int cycles);
        exp_t x;
        x.is_ls = is_ls; x.we = we; x.addr = a; x.wdata = wd;
        x.rdata = rd; x.err = e; x.cycles = cycles;
        exp_q.push_back(x);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {24'b0, f_gnt, f_done, ls_gnt, ls_done, err, busy, mem_req, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d transactions still pending after %0d cycles", exp_q.size(), max_cycles);
        exp_q.delete();
    endtask

    // Memory model: answers after mem_wait stall cycles of an active request.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (bus_cnt == mem_wait);
            mem_rdata = mem_ready ? mem_val(mem_addr) : 32'h0;
            bus_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            bus_cnt   = 0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err && !(f_done || ls_done)) fail("err_without_done");
            if (f_gnt || ls_gnt) begin
                gnt_cyc = cyc;
                mon_cnt = 0;
                if (exp_q.size() == 0) fail("gnt_unexpected");
                else begin
                    chk("gnt_owner_ls", {31'b0, ls_gnt}, {31'b0, exp_q[0].is_ls});
                    chk("gnt_onehot", {31'b0, f_gnt & ls_gnt}, 32'h0);
                end
            end
            if (mem_req) begin
                mon_cnt++;
                if (exp_q.size() == 0) fail("mem_req_unexpected");
                else begin
                    chk("mem_we", {31'b0, mem_we}, {31'b0, exp_q[0].we});
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                end
            end
            if (f_done || ls_done) begin
                done_cyc = cyc;
                if (exp_q.size() == 0) fail("done_unexpected");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_owner_ls", {31'b0, ls_done}, {31'b0, e.is_ls});
                    chk("done_onehot", {31'b0, f_done & ls_done}, 32'h0);
                    chk("done_rdata", rdata, e.rdata);
                    chk("done_err", {31'b0, err}, {31'b0, e.err});
                    chk("bus_cycles", mon_cnt, e.cycles);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single zero-wait fetch with latency checks.
        #1;
        mem_wait = 0;
        push(0, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 1);
        f_addr = 32'h40; f_req = 1'b1; t0 = cyc;
        wait_drain(20);
        f_req = 1'b0;
        chk("fetch_gnt_latency", gnt_cyc - t0, 1);
        chk("fetch_done_latency", done_cyc - t0, 2);
        @(negedge clk);
        #1;
        chk("fetch_busy_after", {31'b0, busy}, 32'h0);
        chk("fetch_idle_latency", cyc - t0, 3);

        // Store with 3 wait states; inputs scrambled after grant must be ignored.
        mem_wait = 3;
        push(1, 1, 32'h100, 32'h1234_5678, 32'h0, 0, 4);
        ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'h1234_5678; ls_req = 1'b1;
        for (int i = 0; i < 10 && !ls_gnt; i++) @(negedge clk);
        #1;
        ls_addr = 32'hFFFF_FFF0; ls_wdata = 32'h0;
        wait_drain(20);
        ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk);

        // Contention: LS x4 then F, twice.
        #1;
        mem_wait = 0;
        f_addr = 32'h200; ls_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push(0, 0, 32'h200, 32'h0, mem_val(32'h200), 0, 1);
            else            push(1, 0, 32'h300, 32'h0, mem_val(32'h300), 0, 1);
        end
        f_req = 1'b1; ls_req = 1'b1;
        wait_drain(100);
        f_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);

        // Memory never answers: timeout after 255 BUS cycles, then normal service.
        #1;
        mem_wait = NEVER;
        f_addr = 32'h80;
        push(0, 0, 32'h80, 32'h0, 32'h0, 1, 255);
        f_req = 1'b1;
        wait_drain(300);
        f_req = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        #1;
        chk("timeout_mem_req_low", {31'b0, mem_req}, 32'h0);
        push(1, 0, 32'h84, 32'h0, mem_val(32'h84), 0, 1);
        ls_addr = 32'h84; ls_req = 1'b1;
        wait_drain(20);
        ls_req = 1'b0;
        @(negedge clk);

        // Ready on the very cycle the timer expires: data wins, no err.
        #1;
        mem_wait = 254;
        push(1, 0, 32'h88, 32'h0, mem_val(32'h88), 0, 255);
        ls_addr = 32'h88; ls_req = 1'b1;
        wait_drain(300);
        ls_req = 1'b0;
        @(negedge clk);

        // Two LS grants under contention, a hung store, reset mid-BUS.
        #1;
        mem_wait = 0;
        f_addr = 32'h200; ls_addr = 32'h300; ls_we = 1'b0;
        push(1, 0, 32'h300, 32'h0, mem_val(32'h300), 0, 1);
        push(1, 0, 32'h300, 32'h0, mem_val(32'h300), 0, 1);
        f_req = 1'b1; ls_req = 1'b1;
        wait_drain(20);
        mem_wait = NEVER; ls_we = 1'b1; ls_wdata = 32'hCAFE_F00D;
        push(1, 1, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 0);
        for (int i = 0; i < 10 && !(mem_req && mem_we); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        chk("store_in_flight", {31'b0, mem_req & mem_we}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("midbus_reset");
        rst_n = 1'b1;
        exp_q.delete();
        mem_wait = 0; ls_we = 1'b0; ls_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) push(0, 0, 32'h200, 32'h0, mem_val(32'h200), 0, 1);
            else        push(1, 0, 32'h300, 32'h0, mem_val(32'h300), 0, 1);
        end
        wait_drain(60);
        f_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("final_busy", {31'b0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
